micro_divider: RTL and testbench

MICRO_DIVIDER -- requirements
Module: micro_divider

---
 rtl/micro_divider.sv | 125 ++++++++++++
 tb/tb_micro_divider.sv | 126 ++++++++++++
 2 files changed

// File: rtl/micro_divider.sv
// Restoring shift-subtract divider for sign-magnitude operands (7-bit / 3-bit magnitudes).
// Define MICRO_DIV_ZERO_CHECK_EN to short-circuit a zero divisor and raise div0.
module micro_divider (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       start,
  input  logic [7:0] dividend,
  input  logic [3:0] divisor,
  output logic [7:0] quotient,
  output logic [3:0] remainder,
  output logic       busy,
  output logic       done,
  output logic       div0
);

  // state | meaning
  // IDLE  | waiting for start
  // CALC  | one quotient bit per edge, 7 iterations
  // FIN   | quotient/remainder complete, registered on exit
  // DONE  | done pulse, results valid
  typedef enum logic [1:0] {IDLE, CALC, FIN, DONE} state_t;

  state_t      state, state_nxt;
  logic [6:0]  dvd;
  logic        dvd_sign;
  logic [3:0]  dsr;
  logic [3:0]  r;
  logic [2:0]  cnt;
  logic [3:0]  trial;
  logic [3:0]  r_nxt;
  logic        qbit;
  logic        zero_div;
  logic        q_sign;
  logic        r_sign;

  // (R<<1)|bit kept to 4 bits; the dropped MSB only matters for a zero divisor
  assign trial    = (r << 1) | {3'b000, dvd[6]};
  assign qbit     = (trial >= {1'b0, dsr[2:0]});
  assign r_nxt    = qbit ? (trial - {1'b0, dsr[2:0]}) : trial;
  assign zero_div = (dsr[2:0] == 3'd0);
  assign q_sign   = (dvd_sign ^ dsr[3]) & (|dvd);
  assign r_sign   = dvd_sign & (|r[2:0]);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = CALC;
      CALC: begin
`ifdef MICRO_DIV_ZERO_CHECK_EN
        if (cnt == 3'd0 && zero_div) state_nxt = DONE;
        else if (cnt == 3'd6)        state_nxt = FIN;
`else
        if (cnt == 3'd6) state_nxt = FIN;
`endif
      end
      FIN:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == CALC) || (state == FIN);
    done = (state == DONE);
  end

`ifdef MICRO_DIV_ZERO_CHECK_EN
  logic div0_r;
  assign div0 = div0_r;
`else
  assign div0 = 1'b0;
`endif

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      dvd       <= '0;
      dvd_sign  <= 1'b0;
      dsr       <= '0;
      r         <= '0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
`ifdef MICRO_DIV_ZERO_CHECK_EN
      div0_r    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (start) begin
          dvd      <= dividend[6:0];
          dvd_sign <= dividend[7];
          dsr      <= divisor;
          r        <= '0;
          cnt      <= '0;
        end
        CALC: begin
          // quotient bits shift in behind the consumed dividend bits
          r   <= r_nxt;
          dvd <= {dvd[5:0], qbit};
          cnt <= cnt + 3'd1;
`ifdef MICRO_DIV_ZERO_CHECK_EN
          if (cnt == 3'd0 && zero_div) begin
            quotient  <= {dvd_sign ^ dsr[3], 7'h7F};
            remainder <= 4'h0;
            div0_r    <= 1'b1;
          end
`endif
        end
        FIN: begin
          quotient  <= {q_sign, dvd};
          remainder <= {r_sign, r[2:0]};
`ifdef MICRO_DIV_ZERO_CHECK_EN
          div0_r    <= 1'b0;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_micro_divider.sv
// Directed self-checking bench for micro_divider; expectations are hand-computed
// and follow MICRO_DIV_ZERO_CHECK_EN when it is defined.
module tb_micro_divider;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] dividend = '0;
  logic [3:0] divisor = '0;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       busy, done, div0;

  int n_cmp = 0;
  int n_bad = 0;

  micro_divider dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start),
    .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder),
    .busy(busy), .done(done), .div0(div0)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // start at E0, optionally re-pulse start with other operands before E3
  task automatic run_div(input string tag, input logic [7:0] a, input logic [3:0] b,
                         input logic [7:0] exp_q, input logic [3:0] exp_r,
                         input int exp_lat, input logic exp_z, input bit repulse);
    logic [7:0] prev_q;
    logic [3:0] prev_r;
    logic       prev_z;
    int lat;
    prev_q = quotient;
    prev_r = remainder;
    prev_z = div0;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    dividend = 8'h13;
    divisor  = 4'h1;
    lat = 0;
    while (!done && lat < 20) begin
      if (repulse && lat == 2) start = 1'b1;
      tick();
      start = 1'b0;
      lat++;
      if (!done) begin
        chk({tag, " busy"}, {7'd0, busy}, 8'd1);
        chk({tag, " q_hold"}, quotient, prev_q);
        chk({tag, " r_hold"}, {4'd0, remainder}, {4'd0, prev_r});
        chk({tag, " z_hold"}, {7'd0, div0}, {7'd0, prev_z});
      end
    end
    chk({tag, " latency"}, lat[7:0], exp_lat[7:0]);
    chk({tag, " quotient"}, quotient, exp_q);
    chk({tag, " remainder"}, {4'd0, remainder}, {4'd0, exp_r});
    chk({tag, " div0"}, {7'd0, div0}, {7'd0, exp_z});
    chk({tag, " busy_done"}, {7'd0, busy}, 8'd0);
    tick();
    chk({tag, " done_pulse"}, {7'd0, done}, 8'd0);
    chk({tag, " q_after"}, quotient, exp_q);
  endtask

  initial begin
    #2;
    chk("rst quotient", quotient, 8'h00);
    chk("rst remainder", {4'd0, remainder}, 8'h00);
    chk("rst busy", {7'd0, busy}, 8'd0);
    chk("rst done", {7'd0, done}, 8'd0);
    chk("rst div0", {7'd0, div0}, 8'd0);
    @(negedge sys_clk);
    sys_rst = 1'b0;

    run_div("pos100_7", 8'h64, 4'h7, 8'h0E, 4'h2, 8, 1'b0, 1'b0);
    run_div("neg100_7", 8'hE4, 4'h7, 8'h8E, 4'hA, 8, 1'b0, 1'b0);
`ifdef MICRO_DIV_ZERO_CHECK_EN
    run_div("div_nzero", 8'h2A, 4'h8, 8'hFF, 4'h0, 1, 1'b1, 1'b0);
`else
    run_div("div_nzero", 8'h2A, 4'h8, 8'hFF, 4'h2, 8, 1'b0, 1'b0);
`endif
    run_div("small_neg6", 8'h05, 4'hE, 8'h00, 4'h5, 8, 1'b0, 1'b0);
    run_div("neg0_dvd", 8'h80, 4'h3, 8'h00, 4'h0, 8, 1'b0, 1'b0);
    run_div("repulse", 8'h64, 4'h7, 8'h0E, 4'h2, 8, 1'b0, 1'b1);

    dividend = 8'h64;
    divisor  = 4'h7;
    start    = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    #3;
    sys_rst = 1'b1;
    #1;
    chk("midrst quotient", quotient, 8'h00);
    chk("midrst remainder", {4'd0, remainder}, 8'h00);
    chk("midrst busy", {7'd0, busy}, 8'd0);
    chk("midrst done", {7'd0, done}, 8'd0);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("midrst no_done", {7'd0, done}, 8'd0);
    end
    run_div("after_rst", 8'h7F, 4'h3, 8'h2A, 4'h1, 8, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
